pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the RV32I 5-stage pipeline. It decides each cycle whether the PC and the IF/ID, ID/EX and EX/MEM registers advance, hold or are squashed to NOP. It covers load-use interlocks, taken branch/jump squashes, multi-cycle data-memory waits with timeout, and post-reset pipeline priming. It also keeps stall and flush event counters for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: PC/IF-ID/ID-EX/EX-MEM stall and squash control for the 5-stage RV32I pipeline,
// with post-reset priming, data-memory wait timeout and saturating stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int INIT_CYCLES = 2,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  d_rs1,
   input  logic [4:0]  d_rs2,
   input  logic        d_use_rs1,
   input  logic        d_use_rs2,
   input  logic [4:0]  e_rd,
   input  logic        e_is_load,
   input  logic        e_jb_taken,
   input  logic        m_mem_req,
   input  logic        m_mem_ack,
   output logic        stall_pc,
   output logic        stall_d,
   output logic        d_valid,
   output logic        stall_e,
   output logic        stall_m,
   output logic        flush_e,
   output logic        mem_err,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);
   typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;
   state_t      state_q, state_d;
   logic [3:0]  init_cnt_q, init_cnt_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        mem_err_q, mem_err_d;
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic        freeze, load_use, timeout, rel;
   always_comb begin
      freeze   = m_mem_req & ~m_mem_ack;
      load_use = e_is_load & (e_rd != 5'd0) &
                 ((d_use_rs1 & (d_rs1 == e_rd)) | (d_use_rs2 & (d_rs2 == e_rd)));
      timeout  = (state_q == MEM_WAIT) & ~m_mem_ack & (wait_cnt_q == 16'(MEM_TIMEOUT));
      rel      = m_mem_ack | timeout;
      stall_pc = 1'b1;
      stall_d  = 1'b0;
      d_valid  = 1'b0;
      flush_e  = 1'b1;
      stall_e  = 1'b0;
      stall_m  = 1'b0;
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = timeout;
      case (state_q)
         INIT: begin
            init_cnt_d = init_cnt_q + 4'd1;
            state_d    = (init_cnt_q == 4'(INIT_CYCLES - 1)) ? RUN : INIT;
         end
         RUN: begin
            // Memory freeze outranks a branch, which outranks a load-use bubble.
            stall_pc   = freeze | (~e_jb_taken & load_use);
            stall_d    = stall_pc;
            stall_e    = freeze;
            stall_m    = freeze;
            flush_e    = ~freeze & (e_jb_taken | load_use);
            d_valid    = freeze | ~e_jb_taken;
            state_d    = freeze ? MEM_WAIT : RUN;
            wait_cnt_d = freeze ? 16'd1 : wait_cnt_q;
         end
         MEM_WAIT: begin
            stall_pc   = ~rel;
            stall_d    = ~rel;
            stall_e    = ~rel;
            stall_m    = ~rel;
            flush_e    = 1'b0;
            d_valid    = 1'b1;
            wait_cnt_d = wait_cnt_q + 16'd1;
            state_d    = rel ? RUN : MEM_WAIT;
         end
         default: state_d = INIT;
      endcase
      stall_cnt_d = (state_q != INIT && stall_pc && !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
      flush_cnt_d = (state_q == RUN && flush_e && !(&flush_cnt_q)) ? flush_cnt_q + 32'd1 : flush_cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= INIT;
         init_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of priming, load-use, branch squash, memory wait/timeout and reset.
module tb_pipe_hazard_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  d_rs1, d_rs2, e_rd;
   logic        d_use_rs1, d_use_rs2, e_is_load, e_jb_taken, m_mem_req, m_mem_ack;
   logic        stall_pc, stall_d, d_valid, stall_e, stall_m, flush_e, mem_err;
   logic [31:0] stall_cnt, flush_cnt;
   logic [5:0]  outs;
   int          n_chk = 0;
   int          n_fail = 0;
   localparam logic [5:0] O_INIT = 6'b100100;
   localparam logic [5:0] O_IDLE = 6'b001000;
   localparam logic [5:0] O_LU   = 6'b111100;
   localparam logic [5:0] O_BR   = 6'b000100;
   localparam logic [5:0] O_FRZ  = 6'b111011;
   pipe_hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
      .e_rd(e_rd), .e_is_load(e_is_load), .e_jb_taken(e_jb_taken), .m_mem_req(m_mem_req), .m_mem_ack(m_mem_ack),
      .stall_pc(stall_pc), .stall_d(stall_d), .d_valid(d_valid), .stall_e(stall_e), .stall_m(stall_m),
      .flush_e(flush_e), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );
   assign outs = {stall_pc, stall_d, d_valid, flush_e, stall_e, stall_m};
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic ld, input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic jb, input logic rq, input logic ak);
      e_is_load = ld; e_rd = rd; d_rs1 = r1; d_use_rs1 = u1; d_rs2 = r2; d_use_rs2 = u2;
      e_jb_taken = jb; m_mem_req = rq; m_mem_ack = ak;
      #1;
   endtask
   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      chk("rst_outs", 32'(outs), 32'(O_INIT));
      chk("rst_mem_err", 32'(mem_err), 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("init_c0", 32'(outs), 32'(O_INIT));
      tick;
      chk("init_c1", 32'(outs), 32'(O_INIT));
      tick;
      chk("run_c2", 32'(outs), 32'(O_IDLE));
      chk("init_stall_cnt", stall_cnt, 0);
      chk("init_flush_cnt", flush_cnt, 0);
      drive(1, 5, 0, 0, 5, 1, 0, 0, 0);
      chk("lu_rs2", 32'(outs), 32'(O_LU));
      tick;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("lu_after", 32'(outs), 32'(O_IDLE));
      chk("lu_stall_cnt", stall_cnt, 1);
      chk("lu_flush_cnt", flush_cnt, 1);
      tick;
      drive(1, 0, 0, 1, 0, 1, 0, 0, 0);
      chk("lu_x0", 32'(outs), 32'(O_IDLE));
      tick;
      chk("x0_stall_cnt", stall_cnt, 1);
      drive(1, 7, 7, 1, 3, 0, 0, 0, 0);
      chk("lu_rs1", 32'(outs), 32'(O_LU));
      tick;
      drive(1, 7, 7, 0, 7, 0, 0, 0, 0);
      chk("lu_unused", 32'(outs), 32'(O_IDLE));
      chk("lu2_stall_cnt", stall_cnt, 2);
      chk("lu2_flush_cnt", flush_cnt, 2);
      tick;
      drive(1, 9, 9, 1, 9, 1, 1, 0, 0);
      chk("br_over_lu", 32'(outs), 32'(O_BR));
      tick;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("br_stall_cnt", stall_cnt, 2);
      chk("br_flush_cnt", flush_cnt, 3);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("mem_c0", 32'(outs), 32'(O_FRZ));
      tick;
      drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
      chk("mem_c1_br_held", 32'(outs), 32'(O_FRZ));
      tick;
      chk("mem_c2", 32'(outs), 32'(O_FRZ));
      tick;
      drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
      chk("mem_ack", 32'(outs), 32'(O_IDLE));
      tick;
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("br_after_wait", 32'(outs), 32'(O_BR));
      chk("mem_stall_cnt", stall_cnt, 5);
      tick;
      chk("bw_flush_cnt", flush_cnt, 4);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("mem_zero", 32'(outs), 32'(O_IDLE));
      tick;
      drive(1, 4, 4, 1, 0, 0, 0, 0, 0);
      chk("run_after_zero", 32'(outs), 32'(O_LU));
      chk("zero_stall_cnt", stall_cnt, 5);
      tick;
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("to_c0", 32'(outs), 32'(O_FRZ));
      tick;
      chk("to_c1", 32'(outs), 32'(O_FRZ));
      tick;
      chk("to_c2", 32'(outs), 32'(O_FRZ));
      tick;
      chk("to_c3", 32'(outs), 32'(O_FRZ));
      tick;
      chk("to_c4_release", 32'(outs), 32'(O_IDLE));
      chk("to_c4_mem_err", 32'(mem_err), 0);
      tick;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("to_c5_mem_err", 32'(mem_err), 1);
      chk("to_c5_outs", 32'(outs), 32'(O_IDLE));
      chk("to_stall_cnt", stall_cnt, 10);
      chk("to_flush_cnt", flush_cnt, 5);
      tick;
      chk("to_c6_mem_err", 32'(mem_err), 0);
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("to_run", 32'(outs), 32'(O_BR));
      tick;
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick;
      chk("rw_wait", 32'(outs), 32'(O_FRZ));
      rst = 1'b1;
      #1;
      chk("rw_outs", 32'(outs), 32'(O_INIT));
      chk("rw_stall_cnt", stall_cnt, 0);
      chk("rw_flush_cnt", flush_cnt, 0);
      chk("rw_mem_err", 32'(mem_err), 0);
      tick;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rw_init_c0", 32'(outs), 32'(O_INIT));
      tick;
      chk("rw_init_c1", 32'(outs), 32'(O_INIT));
      tick;
      chk("rw_run_c2", 32'(outs), 32'(O_IDLE));
      chk("rw_cnt_end", stall_cnt | flush_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
